cle_label_reader: RTL and testbench
===================================

# cle_label_reader

Read-back unit on the far side of the component-labeling label memory. After labeling finishes, it scans the 32x32 label map (1024 x 8-bit, one label per pixel) in raster order. It re-packs the foreground/background status of every pixel into the 128 x 8-bit packed-bitmap format used by the image ROM, and reports how many distinct component labels were present. It sits after the labeling engine, started by its `finish`, and its packed output lets the bench compare the labeled result against the source image.

## Interface
Parameters:
- none (image geometry fixed at 32x32, 8 pixels per packed byte)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  level/pulse; sampled only in IDLE; connect to labeling engine `finish`
- `lab_a`  out  10  label-memory address, pixel index = {row[4:0], col[4:0]}
- `lab_rd`  out  1  read strobe, active high
- `lab_q`  in  8  label-memory read data, valid the cycle after `lab_a`/`lab_rd`
- `pack_a`  out  7  packed-bitmap byte address
- `pack_d`  out  8  packed byte; bit 7 = lowest pixel index of the byte
- `pack_wen`  out  1  packed-bitmap write enable, active low, one cycle per byte
- `busy`  out  1  high while scanning
- `done`  out  1  one-cycle pulse at scan end
- `label_count`  out  8  distinct nonzero labels seen in last completed scan

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start`=1 -> RUN; `label_count` and the seen-set are cleared, and `lab_a`=0, `lab_rd`=1.
- RUN: `lab_a` increments by 1 each cycle, 0..1023. On `lab_a`=1023, next state is DRAIN and `lab_rd`=0.
- DRAIN: runs 2 cycles to collect the last two read returns, then moves to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, and `label_count` is updated. Next state is IDLE.
- Bit packing: pixel p contributes `|lab_q` (nonzero label = 1) to bit 7-p[2:0] of byte p[9:3].
    - Bits are assembled in an 8-bit shift register, MSB first.
    - On capture of the pixel with p[2:0]=7, the block drives `pack_a`=p[9:3], `pack_d`=assembled byte and `pack_wen`=0 for exactly one cycle.
- Label counting: a 256-entry seen vector. Each captured `lab_q`≠0 sets bit `lab_q`. `label_count` = popcount of the seen vector, taken at DONE.
    - Maximum count is 255, since label 0 is excluded, so the 8-bit count needs no saturation.
- Label value 0 means background; there is no other label interpretation or remapping.
- `start` in RUN/DRAIN/DONE is ignored. `start` held high through DONE re-triggers from IDLE on the following cycle.
- Asynchronous reset mid-scan:
    - All state returns to reset values immediately, and the partially assembled byte is discarded (no write).
    - `label_count` returns to 0.

## Timing
- Reset values: `lab_a`=0, `lab_rd`=0, `pack_a`=0, `pack_d`=0, `pack_wen`=1, `busy`=0, `done`=0, `label_count`=0.
- All outputs are registered.
- Let E0 be the edge that samples `start`=1 in IDLE.
- After edge Ek (k=0..1023), `lab_a`=k. `lab_q` for pixel k is sampled at E(k+2).
- The write of byte b is registered at E(8b+9) and visible for one cycle. The last write (b=127) is registered at E(1025).
- `done`=1 and `busy`=0 are registered at E(1026); `label_count` is valid from the same edge and held until the next start.
- `busy` is high from E0 through E1026; the scan takes 1026 cycles.
- Consecutive writes are 8 cycles apart; `pack_wen` is never low on two adjacent cycles.

## Configuration
- Macro `CLE_READER_COUNT_EN`.
- Defined: the seen vector, popcount logic and `label_count` are implemented as described.
- Undefined:
    - There is no seen vector or popcount logic, and `label_count` is held at 0.
    - Packing, timing and `done` are unchanged.

## Test plan
- All-zero label map, `start` pulse -> 128 writes of `pack_d`=0x00 to `pack_a`=0..127, `done` at E1026, `label_count`=0.
- Label map with every pixel=1 -> every `pack_d`=0xFF, `label_count`=1.
- Only pixel 0 (label 3) and pixel 1023 (label 200) nonzero -> `pack_a`=0 gets 0x80, `pack_a`=127 gets 0x01, `label_count`=2.
- Checkerboard with labels 1..255 cycling on foreground pixels -> each byte alternates 0xAA/0x55 per row parity, `label_count`=255. Rerun with `CLE_READER_COUNT_EN` undefined -> same bytes, `label_count`=0.
- Assert `reset` low at cycle 500 of a scan -> outputs immediately at reset values, no further writes. A new `start` produces a full, correct 1026-cycle scan.
- `start` re-pulsed at cycle 300 of a scan -> ignored; exactly 128 writes and one `done`.

Source files
------------

// File: rtl/cle_label_reader.sv
// cle_label_reader: raster read-back of the 32x32 label map. Pixels are
// re-packed into 128 foreground bytes (MSB = lowest pixel index), and the
// number of distinct nonzero labels is reported at scan end.
// Optional feature macro: CLE_READER_COUNT_EN enables the seen vector and
// popcount behind label_count. When the macro is undefined, label_count is tied to 0.
module cle_label_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [9:0] lab_a,
  output logic       lab_rd,
  input  logic [7:0] lab_q,
  output logic [6:0] pack_a,
  output logic [7:0] pack_d,
  output logic       pack_wen,
  output logic       busy,
  output logic       done,
  output logic [7:0] label_count
);

  localparam int unsigned PIX_W    = 10;
  localparam int unsigned BYTE_AW  = 7;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned LAST_PIX = 1023;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [PIX_W-1:0]   r_lab_a;
  logic               r_lab_rd;
  logic               r_drain;
  logic               r_busy;
  logic               r_done;
  logic [PIX_W-1:0]   r_pix1;
  logic               r_v1;
  logic [DATA_W-1:0]  r_shift;
  logic [BYTE_AW-1:0] r_pack_a;
  logic [DATA_W-1:0]  r_pack_d;
  logic               r_pack_wen;
  logic [DATA_W-1:0]  r_label_count;
  logic               w_start_scan;
  logic               w_fg;
  logic [DATA_W-1:0]  w_byte;
  logic [DATA_W-1:0]  w_popcount;

  assign w_start_scan = (r_state == S_IDLE) && start;
  assign w_fg         = |lab_q;
  assign w_byte       = {r_shift[DATA_W-2:0], w_fg};

  // Scan sequencer: address generation, drain of the read pipeline, done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_lab_a       <= '0;
      r_lab_rd      <= 1'b0;
      r_drain       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_label_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_RUN;
            r_lab_a       <= '0;
            r_lab_rd      <= 1'b1;
            r_busy        <= 1'b1;
            r_drain       <= 1'b0;
            r_label_count <= '0;
          end
        end
        S_RUN: begin
          if (r_lab_a == PIX_W'(LAST_PIX)) begin
            r_state  <= S_DRAIN;
            r_lab_rd <= 1'b0;
          end else begin
            r_lab_a <= r_lab_a + PIX_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_label_count <= w_popcount;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-return pipeline: remember which pixel the memory is answering for
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1   <= 1'b0;
      r_pix1 <= '0;
    end else begin
      r_v1   <= r_lab_rd;
      r_pix1 <= r_lab_a;
    end
  end

  // Bit packing: shift in foreground bits MSB first, write on the 8th pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_pack_a   <= '0;
      r_pack_d   <= '0;
      r_pack_wen <= 1'b1;
    end else begin
      r_pack_wen <= 1'b1;
      if (w_start_scan) begin
        r_shift <= '0;
      end else if (r_v1) begin
        r_shift <= w_byte;
        if (r_pix1[2:0] == 3'd7) begin
          r_pack_a   <= r_pix1[PIX_W-1:3];
          r_pack_d   <= w_byte;
          r_pack_wen <= 1'b0;
        end
      end
    end
  end

`ifdef CLE_READER_COUNT_EN
  localparam int unsigned NUM_LABELS = 256;
  localparam int unsigned CNT_W      = 9;

  logic [NUM_LABELS-1:0] r_seen;
  logic [CNT_W-1:0]      w_pop_sum;

  // Seen vector: one bit per nonzero label value returned during the scan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seen <= '0;
    end else if (w_start_scan) begin
      r_seen <= '0;
    end else if (r_v1 && w_fg) begin
      r_seen[lab_q] <= 1'b1;
    end
  end

  // Popcount of the seen vector; bit 0 is never set so the sum fits 8 bits
  always_comb begin
    w_pop_sum = '0;
    for (int i = 0; i < NUM_LABELS; i++) begin
      w_pop_sum = w_pop_sum + CNT_W'(r_seen[i]);
    end
  end

  assign w_popcount = DATA_W'(w_pop_sum);
`else
  assign w_popcount = '0;
`endif

  assign lab_a       = r_lab_a;
  assign lab_rd      = r_lab_rd;
  assign pack_a      = r_pack_a;
  assign pack_d      = r_pack_d;
  assign pack_wen    = r_pack_wen;
  assign busy        = r_busy;
  assign done        = r_done;
  assign label_count = r_label_count;

endmodule

// File: tb/tb_cle_label_reader.sv
// Self-checking bench for cle_label_reader: label memory model, reference
// packing/counting computed from the label map, directed and random maps.
module tb_cle_label_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] lab_a;
  logic       lab_rd;
  logic [7:0] lab_q;
  logic [6:0] pack_a;
  logic [7:0] pack_d;
  logic       pack_wen;
  logic       busy;
  logic       done;
  logic [7:0] label_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [1024];
  logic [7:0] exp_bytes [128];
  int         exp_count;

  cle_label_reader dut (
    .clk(clk), .reset(reset), .start(start),
    .lab_a(lab_a), .lab_rd(lab_rd), .lab_q(lab_q),
    .pack_a(pack_a), .pack_d(pack_d), .pack_wen(pack_wen),
    .busy(busy), .done(done), .label_count(label_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read label memory: data one cycle after address/strobe
  initial lab_q = 8'h00;
  always @(posedge clk) if (lab_rd) lab_q <= mem[lab_a];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: bytes from foreground status, count of distinct nonzero labels
  task automatic build_model();
    bit seen [256];
    int cnt;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int b = 0; b < 128; b++) begin
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < 8; i++)
        if (mem[8*b+i] != 8'h00) v = v | (8'h80 >> i);
      exp_bytes[b] = v;
    end
    cnt = 0;
    for (int p = 0; p < 1024; p++) seen[mem[p]] = 1'b1;
    for (int l = 1; l < 256; l++) if (seen[l]) cnt++;
`ifdef CLE_READER_COUNT_EN
    exp_count = cnt;
`else
    exp_count = 0;
`endif
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int p = 0; p < 1024; p++) mem[p] = v;
  endtask

  task automatic fill_checker();
    int j;
    j = 0;
    for (int p = 0; p < 1024; p++) begin
      if ((((p >> 5) + (p & 31)) % 2) == 0) begin
        mem[p] = 8'((j % 255) + 1);
        j++;
      end else begin
        mem[p] = 8'h00;
      end
    end
  endtask

  task automatic fill_random(input int density, input int maxlab);
    for (int p = 0; p < 1024; p++)
      mem[p] = ($urandom_range(99) < density) ? 8'($urandom_range(maxlab, 1)) : 8'h00;
  endtask

  task automatic check_reset_values(input string name);
    check({name, " rst lab_a"},  32'(lab_a), 32'd0);
    check({name, " rst lab_rd"}, 32'(lab_rd), 32'd0);
    check({name, " rst pack_a"}, 32'(pack_a), 32'd0);
    check({name, " rst pack_d"}, 32'(pack_d), 32'd0);
    check({name, " rst wen"},    32'(pack_wen), 32'd1);
    check({name, " rst busy"},   32'(busy), 32'd0);
    check({name, " rst done"},   32'(done), 32'd0);
    check({name, " rst count"},  32'(label_count), 32'd0);
  endtask

  // One scan from a start pulse; k counts edges after E0
  task automatic run_scan(input string name, input int repulse_at, input int reset_at);
    int writes, done_cnt, done_k, adjacent, bad_addr, bad_busy;
    bit prev_low;
    build_model();
    writes = 0; done_cnt = 0; done_k = -1; adjacent = 0;
    bad_addr = 0; bad_busy = 0; prev_low = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " E0 busy"},   32'(busy), 32'd1);
    check({name, " E0 lab_rd"}, 32'(lab_rd), 32'd1);
    check({name, " E0 lab_a"},  32'(lab_a), 32'd0);
    for (int k = 1; k <= 1032; k++) begin
      @(posedge clk); #1;
      if (k == reset_at) begin
        reset = 1'b0;
        #1;
        check_reset_values({name, " midscan"});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          if (!pack_wen || done || busy) bad_busy++;
        end
        check({name, " quiet after reset"}, 32'(bad_busy), 32'd0);
        return;
      end
      if (k == repulse_at) start = 1'b1;
      if (k == repulse_at + 1) start = 1'b0;
      if (k <= 1023 && (32'(lab_a) != 32'(k) || !lab_rd)) bad_addr++;
      if (k >= 1024 && lab_rd) bad_addr++;
      if (busy !== (k < 1026)) bad_busy++;
      if (!pack_wen) begin
        if (prev_low) adjacent++;
        check($sformatf("%s write order %0d", name, writes), 32'(pack_a), 32'(writes));
        check($sformatf("%s pack_d[%0d]", name, pack_a), 32'(pack_d), 32'(exp_bytes[pack_a]));
        check($sformatf("%s write edge [%0d]", name, pack_a), 32'(k), 32'(8 * int'(pack_a) + 9));
        writes++;
      end
      prev_low = !pack_wen;
      if (done) begin
        done_cnt++;
        done_k = k;
        check({name, " count at done"}, 32'(label_count), 32'(exp_count));
      end
    end
    check({name, " write total"}, 32'(writes), 32'd128);
    check({name, " done pulses"}, 32'(done_cnt), 32'd1);
    check({name, " done edge"},   32'(done_k), 32'd1026);
    check({name, " adjacent wen"}, 32'(adjacent), 32'd0);
    check({name, " address seq"}, 32'(bad_addr), 32'd0);
    check({name, " busy window"}, 32'(bad_busy), 32'd0);
    check({name, " count held"},  32'(label_count), 32'(exp_count));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    fill_const(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("idle");

    fill_const(8'h00);
    run_scan("zero", -10, -10);
    fill_const(8'h01);
    run_scan("ones", -10, -10);
    fill_const(8'h00);
    mem[0] = 8'd3;
    mem[1023] = 8'd200;
    run_scan("corners", -10, -10);
    check("corners byte0", 32'(exp_bytes[0]), 32'h80);
    check("corners byte127", 32'(exp_bytes[127]), 32'h01);
    fill_checker();
    run_scan("checker", -10, -10);
    for (int t = 0; t < 3; t++) begin
      fill_random(10 + 35 * t, 1 + $urandom_range(254));
      run_scan($sformatf("rand%0d", t), -10, -10);
    end
    fill_random(50, 255);
    run_scan("repulse", 300, -10);
    fill_random(60, 40);
    run_scan("reset", -10, 500);
    run_scan("after_reset", -10, -10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
